// File: rtl/pipeline_slice.sv
// Pipeline register slice with valid/ready handshake, flush and optional skid entry.
// Empty slots always present BUBBLE_VALUE downstream.
module pipeline_slice #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      SKID         = 1,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    if (SKID != 0) begin : g_skid
        typedef enum logic [1:0] {
            StEmpty    = 2'd0,
            StFull     = 2'd1,
            StSkidFull = 2'd2
        } state_e;

        state_e           state_q;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;
        logic             ready_q;
        logic             valid_q;
        logic             in_xfer;
        logic             out_xfer;

        assign in_xfer  = in_valid && ready_q;
        assign out_xfer = valid_q && out_ready;

        // ready_q and valid_q shadow the state so every output is a flop.
        always_ff @(posedge clk) begin
            if (!rst || flush) begin
                state_q <= StEmpty;
                main_q  <= BUBBLE_VALUE;
                skid_q  <= BUBBLE_VALUE;
                ready_q <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    StEmpty: begin
                        if (in_xfer) begin
                            state_q <= StFull;
                            main_q  <= in_data;
                            valid_q <= 1'b1;
                        end
                    end
                    StFull: begin
                        if (in_xfer && out_xfer) begin
                            main_q <= in_data;
                        end else if (in_xfer) begin
                            state_q <= StSkidFull;
                            skid_q  <= in_data;
                            ready_q <= 1'b0;
                        end else if (out_xfer) begin
                            state_q <= StEmpty;
                            main_q  <= BUBBLE_VALUE;
                            valid_q <= 1'b0;
                        end
                    end
                    StSkidFull: begin
                        if (out_xfer) begin
                            state_q <= StFull;
                            main_q  <= skid_q;
                            skid_q  <= BUBBLE_VALUE;
                            ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StEmpty;
                        main_q  <= BUBBLE_VALUE;
                        skid_q  <= BUBBLE_VALUE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end

        assign in_ready  = ready_q;
        assign out_valid = valid_q;
        assign out_data  = main_q;
        assign occupancy = state_q;
    end else begin : g_direct
        logic             valid_q;
        logic [WIDTH-1:0] main_q;

        // Legacy stall behaviour: downstream ready passes straight through.
        assign in_ready = !valid_q || out_ready;

        always_ff @(posedge clk) begin
            if (!rst || flush) begin
                valid_q <= 1'b0;
                main_q  <= BUBBLE_VALUE;
            end else if (in_valid && in_ready) begin
                valid_q <= 1'b1;
                main_q  <= in_data;
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
                main_q  <= BUBBLE_VALUE;
            end
        end

        assign out_valid = valid_q;
        assign out_data  = main_q;
        assign occupancy = {1'b0, valid_q};
    end

endmodule

// File: tb/tb_pipeline_slice.sv
// Bench for pipeline_slice: one skid and one direct instance share stimulus, each
// checked against a queue model, plus hand-computed vectors and corner sequences.
module tb_pipeline_slice;
    localparam int unsigned W   = 16;
    localparam logic [W-1:0] BUB = 16'hBEEF;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         ir1, ov1, ir0, ov0;
    logic [W-1:0] od1, od0;
    logic [1:0]   oc1, oc0;

    pipeline_slice #(.WIDTH(W), .SKID(1), .BUBBLE_VALUE(BUB)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .occupancy(oc1)
    );

    pipeline_slice #(.WIDTH(W), .SKID(0), .BUBBLE_VALUE(BUB)) u_direct (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .occupancy(oc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit model_on = 0;
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];

    typedef struct {
        logic         rst;
        logic         flush;
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         ov;
        logic [W-1:0] od;
        logic [1:0]   occ;
        logic         ir;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic r, logic f, logic iv, logic [W-1:0] id, logic ordy,
                                logic ov, logic [W-1:0] od, logic [1:0] occ, logic ir);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_models();
        chk("skid_out_valid", 32'(ov1), 32'(q1.size() != 0));
        chk("skid_out_data", 32'(od1), 32'((q1.size() != 0) ? q1[0] : BUB));
        chk("skid_occupancy", 32'(oc1), 32'(q1.size()));
        chk("skid_in_ready", 32'(ir1), 32'(q1.size() < 2));
        chk("direct_out_valid", 32'(ov0), 32'(q0.size() != 0));
        chk("direct_out_data", 32'(od0), 32'((q0.size() != 0) ? q0[0] : BUB));
        chk("direct_occupancy", 32'(oc0), 32'(q0.size()));
        chk("direct_in_ready", 32'(ir0), 32'((q0.size() == 0) || out_ready));
    endtask

    // Check model against DUT with current inputs settled, then clock one edge.
    task automatic step();
        bit in1, out1, in0, out0;
        if (model_on) check_models();
        in1  = in_valid && (q1.size() < 2);
        out1 = (q1.size() != 0) && out_ready;
        in0  = in_valid && ((q0.size() == 0) || out_ready);
        out0 = (q0.size() != 0) && out_ready;
        @(posedge clk);
        if (!rst || flush) begin
            q1.delete();
            q0.delete();
            if (!rst) model_on = 1;
        end else begin
            if (out1) void'(q1.pop_front());
            if (in1) q1.push_back(in_data);
            if (out0) void'(q0.pop_front());
            if (in0) q0.push_back(in_data);
        end
        #1;
    endtask

    initial begin
        logic [W-1:0] bub_in[5];
        logic         bub_iv[5];
        logic         bub_ov[5];
        logic [W-1:0] bub_od[5];

        tbl[0]  = mk(0, 0, 1, 16'hDEAD, 1, 0, BUB,     0, 1);
        tbl[1]  = mk(1, 0, 1, 16'h0001, 1, 0, BUB,     0, 1);
        tbl[2]  = mk(1, 0, 1, 16'h0002, 1, 1, 16'h0001, 1, 1);
        tbl[3]  = mk(1, 0, 1, 16'h0003, 1, 1, 16'h0002, 1, 1);
        tbl[4]  = mk(1, 0, 1, 16'h0004, 1, 1, 16'h0003, 1, 1);
        tbl[5]  = mk(1, 0, 0, 16'h0000, 1, 1, 16'h0004, 1, 1);
        tbl[6]  = mk(1, 0, 0, 16'h0000, 1, 0, BUB,     0, 1);
        tbl[7]  = mk(1, 0, 1, 16'h000A, 1, 0, BUB,     0, 1);
        tbl[8]  = mk(1, 0, 1, 16'h000B, 0, 1, 16'h000A, 1, 1);
        tbl[9]  = mk(1, 0, 1, 16'h000C, 0, 1, 16'h000A, 2, 0);
        tbl[10] = mk(1, 0, 1, 16'h000C, 1, 1, 16'h000A, 2, 0);
        tbl[11] = mk(1, 0, 1, 16'h000C, 1, 1, 16'h000B, 1, 1);
        tbl[12] = mk(1, 0, 0, 16'h0000, 1, 1, 16'h000C, 1, 1);
        tbl[13] = mk(1, 0, 0, 16'h0000, 1, 0, BUB,     0, 1);
        tbl[14] = mk(1, 0, 1, 16'h0011, 0, 0, BUB,     0, 1);
        tbl[15] = mk(1, 0, 1, 16'h0022, 0, 1, 16'h0011, 1, 1);
        tbl[16] = mk(1, 1, 1, 16'h0055, 0, 1, 16'h0011, 2, 0);
        tbl[17] = mk(1, 0, 0, 16'h0000, 1, 0, BUB,     0, 1);
        tbl[18] = mk(1, 1, 1, 16'h0066, 1, 0, BUB,     0, 1);
        tbl[19] = mk(1, 0, 1, 16'h0077, 1, 0, BUB,     0, 1);
        tbl[20] = mk(1, 0, 0, 16'h0000, 1, 1, 16'h0077, 1, 1);
        tbl[21] = mk(1, 0, 0, 16'h0000, 1, 0, BUB,     0, 1);

        rst = 0; flush = 0; in_valid = 1; in_data = 16'hDEAD; out_ready = 1;
        #1;
        step();
        step();

        foreach (tbl[i]) begin
            rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
            in_data = tbl[i].id; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(ov1), 32'(tbl[i].ov));
            chk($sformatf("vec%0d_out_data", i), 32'(od1), 32'(tbl[i].od));
            chk($sformatf("vec%0d_occupancy", i), 32'(oc1), 32'(tbl[i].occ));
            chk($sformatf("vec%0d_in_ready", i), 32'(ir1), 32'(tbl[i].ir));
            step();
        end

        // Direct slice: a one-cycle hole upstream gives exactly one bubble downstream.
        bub_in = '{16'h0021, 16'h0022, 16'h0000, 16'h0023, 16'h0000};
        bub_iv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        bub_ov = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        bub_od = '{16'h0021, 16'h0022, BUB, 16'h0023, BUB};
        rst = 1; flush = 0; out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = bub_iv[i];
            in_data  = bub_in[i];
            #1;
            step();
            chk($sformatf("bubble%0d_out_valid", i), 32'(ov0), 32'(bub_ov[i]));
            chk($sformatf("bubble%0d_out_data", i), 32'(od0), 32'(bub_od[i]));
        end

        // Flush while full with a beat offered: that beat must never surface.
        in_valid = 1; in_data = 16'h0031; out_ready = 0; #1; step();
        in_data = 16'h0032; #1; step();
        flush = 1; in_data = 16'h0055; #1; step();
        flush = 0; in_valid = 0; out_ready = 1; #1;
        chk("flush_skid_occupancy", 32'(oc1), 32'(0));
        chk("flush_skid_out_valid", 32'(ov1), 32'(0));
        chk("flush_direct_out_valid", 32'(ov0), 32'(0));
        step();
        chk("flush_no_0x55", 32'(od1 == 16'h0055 || od0 == 16'h0055), 32'(0));

        for (int c = 0; c < 10000; c++) begin
            rst       = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (model_on && (c % 8 == 0)) begin
                out_ready = ~out_ready;
                #1;
                chk("skid_in_ready_vs_out_ready", 32'(ir1), 32'(q1.size() < 2));
                out_ready = ~out_ready;
                #1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_slice.md
# pipeline_slice

Parametrised pipeline register slice that replaces stall-driven stage registers with a valid/ready handshake, flush, and an optional skid buffer. One instance sits between two adjacent CPU pipeline stages. It carries one WIDTH-bit payload bundle per transfer. Empty slots present BUBBLE_VALUE downstream, so a non-valid slot is always a clean bubble.

## Interface
- WIDTH, 32: payload width in bits, ≥1.
- SKID, 1: 1 selects a two-entry skid slice with registered in_ready; 0 selects a one-entry slice with combinational in_ready.
- BUBBLE_VALUE, {WIDTH{1'b0}}: value driven on out_data while out_valid=0, and the reset/flush value of every data register.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset.
- flush  input  1  discards all held entries at the next edge.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  slice can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data is a real entry.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  WIDTH  head payload, or BUBBLE_VALUE when empty.
- occupancy  output  2  entries held: 0..1 when SKID=0, 0..2 when SKID=1.

## Operation
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Priority at each edge: reset (rst=0), then flush, then normal transfers.
- Reset or flush:
  - State becomes EMPTY; main and skid registers load BUBBLE_VALUE.
  - Any input transfer in that cycle is discarded.
  - An output transfer in that cycle completes normally; downstream owns that data.
- SKID=1 state machine. States: EMPTY (occupancy 0), FULL (1), SKID_FULL (2). in_ready is 1 in EMPTY and FULL and 0 in SKID_FULL; it is a pure register output.
  - EMPTY, in transfer → FULL, main <= in_data.
  - FULL, in and out transfer → FULL, main <= in_data.
  - FULL, in transfer only → SKID_FULL, skid <= in_data.
  - FULL, out transfer only → EMPTY, main <= BUBBLE_VALUE.
  - SKID_FULL, out transfer → FULL, main <= skid, skid <= BUBBLE_VALUE.
  - No transfer in any state → state and data hold.
- SKID=0:
  - Single main register; in_ready = !out_valid || out_ready (combinational from out_ready).
  - In transfer → main <= in_data, valid stays or becomes 1.
  - Out transfer without in transfer → valid <= 0, main <= BUBBLE_VALUE.
  - This mode reproduces legacy stall semantics: stall_next = !out_ready, stall_current = !in_valid inserts a bubble.
- out_data = main register. out_valid = (state != EMPTY).
- occupancy = state encoding. It never exceeds 1 when SKID=0.
- No data is ever duplicated, reordered or dropped except by rst or flush.

## Timing
- Latency: an accepted input appears on out_data/out_valid one cycle after the accepting edge, provided the slice was EMPTY or drained that edge.
- Throughput: one transfer per cycle sustained in both modes while out_ready=1.
- SKID=1: no combinational path from any input to any output; in_ready, out_valid, out_data and occupancy are all registered.
- SKID=0: the only combinational path is out_ready → in_ready.
- Reset values: out_valid=0, out_data=BUBBLE_VALUE, occupancy=0, in_ready=1 (SKID=1) or 1 (SKID=0, since out_valid=0).
- Back-pressure, SKID=1: when out_ready falls, in_ready falls one cycle later. The skid entry absorbs the one in-flight beat.
- Upstream may drop in_valid or change in_data while in_ready=0 without effect on the slice.
- Flush asserted for N cycles: the slice stays EMPTY for those cycles. Accepting resumes the cycle after flush deasserts; in_ready is already 1.

## Test plan
- Reset: drive rst=0 for 2 cycles with in_valid=1, in_data=0xDEAD → out_valid=0, out_data=BUBBLE_VALUE, occupancy=0 after the reset edge.
- Streaming, both SKID values: in_data 1,2,3,4 on consecutive cycles, out_ready=1 → out_data 1,2,3,4 one cycle later each, no bubbles, occupancy=1.
- Skid fill, SKID=1: out_ready=0 from cycle 2 while feeding 0xA,0xB,0xC → occupancy 2, in_ready=0, 0xC not accepted. Raise out_ready → outputs 0xA,0xB, then 0xC once re-offered, in order.
- Bubble insertion, SKID=0: in_valid=0 for 1 cycle mid-stream with out_ready=1 → exactly one out_valid=0 cycle showing BUBBLE_VALUE.
- Flush in SKID_FULL, with in_valid=1 and in_data=0x55 the same cycle → next cycle occupancy=0, out_valid=0, and 0x55 never appears.
- Random: 10k cycles of random in_valid/out_ready/flush against a scoreboard queue → every output matches the queue, occupancy matches the model, and in_ready has no dependence on same-cycle out_ready when SKID=1.
